seq_detector: RTL
=================

// Module: seq_detector
// PURPOSE
//  Serial pattern detector and frame-lock monitor. Consumes the 1-bit stream from
//  the sequence generators (out port) and flags each occurrence of an N-bit pattern.
//  Declares lock once the pattern repeats at a fixed period.
//  Counts hits and reports lost bits, for checking generator output on the bench or on silicon.
// PARAMETERS
//  N        6          pattern / window width in bits
//  PAT_RST  6'b100111  pattern register value after reset
//  PERIOD   6          expected bit distance between consecutive matches (>=1)
//  LOCK_CNT 3          matches at period spacing needed to lock, first hit included (>=2)
//  MISS_CNT 2          consecutive missed matches that drop lock (>=1)
//  CW       8          width of hit counter
// PORTS
//  clk       in   1   rising-edge clock; the only clock
//  rst       in   1   reset, synchronous, active-low
//  din_en    in   1   din is valid this cycle; all state advances only on din_en
//  din       in   1   serial data bit (first bit in = MSB of pattern)
//  pat_load  in   1   load pat into pattern register and restart detection
//  pat       in   N   new pattern
//  hit       out  1   1-cycle pulse: window matched pattern
//  locked    out  1   level: frame lock held
//  bit_err   out  1   1-cycle pulse: expected match missing while LOCKED
//  hit_cnt   out  CW  saturating count of hit pulses
// BEHAVIOUR
//  - Reset (rst==0 at clk edge):
//      - window=0; fill=0; pattern=PAT_RST; state=SEARCH.
//      - Outputs: hit=0, locked=0, bit_err=0, hit_cnt=0.
//  - Window: on din_en, win <= {win[N-2:0],din}; fill counts to N, then holds.
//  - nxt = {win[N-2:0],din}. m = din_en & (fill>=N-1) & (nxt==pattern).
//  - Outputs are registered; hit equals m delayed by one cycle.
//  - Overlapping matches count; each is a separate hit.
//  - hit_cnt increments on each m. It saturates at 2^CW-1 and never wraps.
//  - FSM, evaluated only on din_en cycles; ph = phase count; g = good count; k = miss count:
//      - SEARCH: m -> VERIFY with ph=0, g=1. Otherwise stay in SEARCH.
//      - VERIFY: ph advances mod PERIOD. At ph==PERIOD-1:
//          - m: g++. When g reaches LOCK_CNT -> LOCKED, k=0.
//          - no m: -> SEARCH.
//      - LOCKED: ph advances mod PERIOD. At ph==PERIOD-1:
//          - m: k=0.
//          - no m: k++ and bit_err pulses next cycle. When k reaches MISS_CNT -> SEARCH.
//      - Off-phase matches do not affect the FSM; they still raise hit.
//  - locked = (state==LOCKED), registered.
//      - It rises in the cycle after the locking din_en, together with that hit.
//      - It falls in the cycle after the final miss, together with bit_err.
//  - pat_load (synchronous, any state):
//      - pattern<=pat; win=0, fill=0; state=SEARCH; hit_cnt=0.
//      - Next-cycle outputs: hit=0, bit_err=0, locked=0.
//      - If din_en is high in the same cycle, pat_load wins and that din bit is discarded.
//  - rst has priority over pat_load.
//  - No din_en: all state holds. hit and bit_err are 0 in the next cycle.
//  - Stalls (din_en gaps) never alter phase alignment.
// STRUCTURE
//  - Shared package: FSM state encoding (SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2) and PAT_RST default.
//  - Unreachable state code 2'd3 returns to SEARCH on the next din_en (self-healing).
//  - One sub-module, seq_window: shift register, fill counter and comparator.
//      - It produces m and takes clear from pat_load.
//  - Top level: FSM, phase/good/miss counters, hit_cnt and output registers.
// TESTING
//  1. Reset, then continuous din_en, stream 100111 repeated:
//     - hit after bits 6, 12, 18, ...
//     - locked rises with the 3rd hit; hit_cnt=3.
//  2. Locked, then one period with 1 bit flipped: bit_err=1 once, locked stays 1.
//     Two flipped periods: locked=0 with the 2nd bit_err.
//  3. Insert din_en=0 gaps of 1..5 cycles between bits in scenario 1:
//     same hit sequence in din_en time; locked still after the 3rd hit.
//  4. pat=6'b101010, pat_load, stream 1010101010:
//     overlapping hits after bits 6, 8 and 10; PERIOD=6 never locks; hit_cnt=3.
//  5. CW=2, 5 matches: hit_cnt = 1, 2, 3, 3, 3 (saturates).
//  6. rst=0 mid-VERIFY, and separately pat_load together with din_en:
//     - Next cycle: all outputs 0.
//     - The discarded din bit does not enter the window; the next hit needs N fresh bits.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding and default pattern.
package seq_detector_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [5:0] PAT_RST_DEF = 6'b100111;

endpackage

// File: rtl/seq_detector_if.sv
// Stream, pattern-load and status signals of the serial pattern detector.
interface seq_detector_if #(
    parameter int N  = 6,
    parameter int CW = 8
);
    logic          din_en;
    logic          din;
    logic          pat_load;
    logic [N-1:0]  pat;
    logic          hit;
    logic          locked;
    logic          bit_err;
    logic [CW-1:0] hit_cnt;

    modport master (
        output din_en, din, pat_load, pat,
        input  hit, locked, bit_err, hit_cnt
    );

    modport slave (
        input  din_en, din, pat_load, pat,
        output hit, locked, bit_err, hit_cnt
    );
endinterface

// File: rtl/seq_window.sv
// Serial shift window with fill counter; flags a match of the incoming window against the pattern.
module seq_window #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_din,
    input  logic         i_clear,
    input  logic [N-1:0] i_pattern,
    output logic         o_match
);
    localparam int FW = $clog2(N + 1);

    logic [N-1:0]  r_win;
    logic [FW-1:0] r_fill;
    logic [N-1:0]  w_nxt;

    assign w_nxt   = {r_win[N-2:0], i_din};
    // A clear in the same cycle discards the incoming bit, so it can never match.
    assign o_match = i_en & ~i_clear & (r_fill >= FW'(N - 1)) & (w_nxt == i_pattern);

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_en) begin
            r_win <= w_nxt;
            if (r_fill != FW'(N))
                r_fill <= r_fill + 1'b1;
        end
    end
endmodule

// File: rtl/seq_detector.sv
// Pattern detector top: frame-lock FSM with phase/good/miss counters and saturating hit counter.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int           N        = 6,
    parameter logic [N-1:0] PAT_RST  = N'(PAT_RST_DEF),
    parameter int           PERIOD   = 6,
    parameter int           LOCK_CNT = 3,
    parameter int           MISS_CNT = 2,
    parameter int           CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_detector_if.slave bus
);
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int KW = $clog2(MISS_CNT + 1);

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_pattern;
    logic [PW-1:0] r_ph, w_ph_nxt, w_ph_adv;
    logic [GW-1:0] r_good, w_good_nxt;
    logic [KW-1:0] r_miss, w_miss_nxt;
    logic          r_hit, r_locked, r_bit_err;
    logic [CW-1:0] r_hit_cnt, w_hit_cnt_nxt;
    logic          w_m, w_at_end, w_err;

    seq_window #(.N(N)) u_window (
        .clk       (clk),
        .rst       (rst),
        .i_en      (bus.din_en),
        .i_din     (bus.din),
        .i_clear   (bus.pat_load),
        .i_pattern (r_pattern),
        .o_match   (w_m)
    );

    assign w_at_end = (r_ph == PW'(PERIOD - 1));
    assign w_ph_adv = w_at_end ? '0 : r_ph + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= SEARCH;
            r_ph      <= '0;
            r_good    <= '0;
            r_miss    <= '0;
            r_pattern <= PAT_RST;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_good  <= w_good_nxt;
            r_miss  <= w_miss_nxt;
            if (bus.pat_load)
                r_pattern <= bus.pat;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        if (bus.pat_load) begin
            w_state_nxt = SEARCH;
        end else if (bus.din_en) begin
            case (r_state)
                SEARCH: begin
                    if (w_m) begin
                        w_state_nxt = VERIFY;
                        w_ph_nxt    = '0;
                        w_good_nxt  = GW'(1);
                    end
                end
                VERIFY: begin
                    w_ph_nxt = w_ph_adv;
                    if (w_at_end) begin
                        if (w_m) begin
                            w_good_nxt = r_good + 1'b1;
                            if (r_good + 1'b1 == GW'(LOCK_CNT)) begin
                                w_state_nxt = LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    w_ph_nxt = w_ph_adv;
                    if (w_at_end) begin
                        if (w_m) begin
                            w_miss_nxt = '0;
                        end else begin
                            w_miss_nxt = r_miss + 1'b1;
                            if (r_miss + 1'b1 == KW'(MISS_CNT))
                                w_state_nxt = SEARCH;
                        end
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        w_err         = bus.din_en & ~bus.pat_load & (r_state == LOCKED) & w_at_end & ~w_m;
        w_hit_cnt_nxt = r_hit_cnt;
        if (bus.pat_load)
            w_hit_cnt_nxt = '0;
        else if (w_m && (r_hit_cnt != '1))
            w_hit_cnt_nxt = r_hit_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit     <= 1'b0;
            r_locked  <= 1'b0;
            r_bit_err <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            r_hit     <= w_m;
            r_locked  <= (w_state_nxt == LOCKED);
            r_bit_err <= w_err;
            r_hit_cnt <= w_hit_cnt_nxt;
        end
    end

    assign bus.hit     = r_hit;
    assign bus.locked  = r_locked;
    assign bus.bit_err = r_bit_err;
    assign bus.hit_cnt = r_hit_cnt;
endmodule
